data_memory_sized: RTL and testbench

// - Parametrised data memory for the MIPS datapath: byte-addressed, little-endian, 32-bit words.
// - Adds byte/half/word loads and stores with optional sign extension, a registered read with valid strobe,

---
 rtl/data_memory_sized.sv | 155 +++++++++++++++
 tb/tb_data_memory_sized.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory for the MEM stage: byte/half/word loads and stores,
// registered read with valid strobe, misalignment flagging and an optional post-reset zero-clear.
module data_memory_sized #(
    parameter int unsigned ADDR_W         = 9,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       data_out,
    output logic              read_valid,
    output logic              misaligned,
    output logic              ready
);

    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 2 ** WORD_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] clr_ptr;
    logic [WORD_W-1:0] clr_ptr_next;

    logic [31:0]       mem [DEPTH];

    logic [WORD_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              idle;
    logic              aligned;
    logic              load_fire;
    logic              bad_fire;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic              wr_en;
    logic [WORD_W-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // State and clear-pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next state, request decode, write-port steering and load formatting
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        wr_en        = 1'b0;
        wr_be        = 4'b0000;
        wr_data      = 32'h0;

        word_idx = address[ADDR_W-1:2];
        lane     = address[1:0];
        wr_idx   = word_idx;
        idle     = (state == ST_IDLE);

        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase

        load_fire = idle && mem_read;
        bad_fire  = idle && (mem_read || mem_write) && !aligned;

        rd_word = mem[word_idx];
        rd_byte = 8'(rd_word >> {lane, 3'b000});
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_val = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{sign_ext & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase

        case (state)
            ST_CLEAR: begin
                wr_en        = 1'b1;
                wr_idx       = clr_ptr;
                wr_be        = 4'b1111;
                clr_ptr_next = clr_ptr + WORD_W'(1);
                if (clr_ptr == WORD_W'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (mem_write && aligned) begin
                    wr_en = 1'b1;
                    case (size)
                        2'b00: begin
                            wr_be   = 4'(4'b0001 << lane);
                            wr_data = {4{write_data[7:0]}};
                        end
                        2'b01: begin
                            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                            wr_data = {2{write_data[15:0]}};
                        end
                        default: begin
                            wr_be   = 4'b1111;
                            wr_data = write_data;
                        end
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Lane-masked array write; contents deliberately untouched by reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered outputs; data_out holds between loads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= 32'h0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
            ready      <= !CLEAR_ON_RESET;
        end else begin
            read_valid <= load_fire;
            misaligned <= bad_fire;
            ready      <= (state_next == ST_IDLE);
            if (load_fire) begin
                data_out <= aligned ? load_val : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized self-checking bench for data_memory_sized against a byte-array reference model.
module tb_data_memory_sized;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] data_out;
    logic        read_valid;
    logic        misaligned;
    logic        ready;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  ref_mem [512];
    logic [31:0] exp_data;

    data_memory_sized #(.ADDR_W(9), .CLEAR_ON_RESET(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .size       (size),
        .sign_ext   (sign_ext),
        .data_out   (data_out),
        .read_valid (read_valid),
        .misaligned (misaligned),
        .ready      (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input int a);
        return ref_mem[a & 511];
    endfunction

    // One request cycle: predict from the byte model, clock it, compare, then commit stores.
    task automatic access(input string tag, input logic wr, input logic rd, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        logic        legal;
        logic [31:0] v;
        int          a;
        a          = int'(addr);
        legal      = (sz == 2'd0) || (sz == 2'd1 && addr[0] == 1'b0) || (sz == 2'd2 && addr[1:0] == 2'b00);
        mem_write  = wr;
        mem_read   = rd;
        address    = addr;
        write_data = wd;
        size       = sz;
        sign_ext   = sx;
        if (rd) begin
            if (!legal) v = 32'h0;
            else if (sz == 2'd0) v = sx ? unsigned'(32'(signed'(rb(a)))) : {24'h0, rb(a)};
            else if (sz == 2'd1) v = sx ? unsigned'(32'(signed'({rb(a+1), rb(a)})))
                                        : {16'h0, rb(a+1), rb(a)};
            else v = {rb(a+3), rb(a+2), rb(a+1), rb(a)};
            exp_data = v;
        end
        @(posedge clock);
        #1;
        check({tag, ".rv"},   32'(read_valid), 32'(rd));
        check({tag, ".mis"},  32'(misaligned), 32'((wr || rd) && !legal));
        check({tag, ".data"}, data_out, exp_data);
        if (wr && legal) begin
            if (sz == 2'd0) ref_mem[a] = wd[7:0];
            else if (sz == 2'd1) begin
                ref_mem[a] = wd[7:0]; ref_mem[a+1] = wd[15:8];
            end else begin
                for (int i = 0; i < 4; i++) ref_mem[a+i] = wd[8*i +: 8];
            end
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    // Counts edges from now until ready rises, bounded; pulses seen meanwhile are tallied.
    task automatic count_clear(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (read_valid || misaligned) pulses++;
            if (ready) break;
        end
    endtask

    initial begin
        int n;
        int p;
        reset = 1'b1; address = '0; write_data = '0; mem_write = 0; mem_read = 0; size = 2'd2; sign_ext = 0;
        exp_data = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.ready", 32'(ready), 32'h0);
        check("rst.rv",    32'(read_valid), 32'h0);
        check("rst.mis",   32'(misaligned), 32'h0);
        check("rst.data",  data_out, 32'h0);

        @(negedge clock);
        reset = 1'b0;
        count_clear(n, p);
        check("clear.len", 32'(n), 32'd128);
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

        access("zero0", 0, 1, 9'h000, 0, 2'd2, 0);
        access("zero1", 0, 1, 9'h1FC, 0, 2'd2, 0);
        access("zero2", 0, 1, 9'h0A7, 0, 2'd0, 1);

        access("st_w",   1, 0, 9'h064, 32'hDEADBEEF, 2'd2, 0);
        access("ld_w",   0, 1, 9'h064, 0, 2'd2, 0);
        access("st_b",   1, 0, 9'h065, 32'h00000080, 2'd0, 0);
        access("ld_bs",  0, 1, 9'h065, 0, 2'd0, 1);
        access("ld_bz",  0, 1, 9'h065, 0, 2'd0, 0);
        access("ld_w2",  0, 1, 9'h064, 0, 2'd2, 0);
        access("mis_ld", 0, 1, 9'h063, 0, 2'd1, 1);
        access("mis_st", 1, 0, 9'h066, 32'h12345678, 2'd2, 0);
        access("ill_st", 1, 0, 9'h064, 32'h12345678, 2'd3, 0);
        access("ld_w3",  0, 1, 9'h064, 0, 2'd2, 0);
        access("idle",   0, 0, 9'h064, 0, 2'd2, 0);
        access("st_h",   1, 0, 9'h0F2, 32'hAAAA8001, 2'd1, 0);
        access("ld_hs",  0, 1, 9'h0F2, 0, 2'd1, 1);
        access("ld_hz",  0, 1, 9'h0F2, 0, 2'd1, 0);

        access("pre22",  1, 0, 9'h010, 32'h22222222, 2'd2, 0);
        access("rw_same",1, 1, 9'h010, 32'h11111111, 2'd2, 0);
        access("post11", 0, 1, 9'h010, 0, 2'd2, 0);

        for (int k = 0; k < 600; k++) begin
            logic [8:0] a;
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) a[1:0] = (k[0]) ? 2'b00 : {a[1], 1'b0};
            access("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the clear; requests during clear must be ignored
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mem_write = 1'b1; mem_read = 1'b1; size = 2'd3; address = 9'h033; write_data = 32'hFFFFFFFF;
        p = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clock);
            #1;
            if (ready || read_valid || misaligned) p++;
        end
        check("clear.early", 32'(p), 32'h0);
        reset = 1'b1;
        #2;
        check("rst2.ready", 32'(ready), 32'h0);
        check("rst2.data",  data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        size = 2'd2; address = 9'h064;
        count_clear(n, p);
        check("clear2.len", 32'(n), 32'd128);
        check("clear2.pulses", 32'(p), 32'h0);
        mem_write = 1'b0; mem_read = 1'b0;
        exp_data = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        access("z_a", 0, 1, 9'h064, 0, 2'd2, 0);
        access("z_b", 0, 1, 9'h010, 0, 2'd2, 0);
        access("z_c", 0, 1, 9'h0F2, 0, 2'd1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
